// File: rtl/q15_pkg.sv
// Shared Q15 definitions: 64-bit fixed point, signed 16-bit integer part in
// bits [63:48], 48-bit fraction in bits [47:0]. Used by every Q15 producer
// and consumer (X32->Q15 and Q15->X32 converters, saturation helper).
package q15_pkg;

    localparam int unsigned Q15_W      = 64;
    localparam int unsigned Q15_FRAC   = 48;
    localparam int unsigned X32_W      = 32;
    localparam int unsigned X32_FRAC_W = 5;
    localparam int unsigned SHAMT_W    = 6;

    // Sign-extended 33-bit operand shifted left by up to 48 places, exact.
    localparam int unsigned Q15_WIDE_W = X32_W + 1 + Q15_FRAC;

    localparam logic [Q15_W-1:0] Q15_POS_INF = 64'h7fff_ffff_ffff_ffff;
    localparam logic [Q15_W-1:0] Q15_NEG_INF = 64'h8000_0000_0000_0001;
    localparam logic [Q15_W-1:0] Q15_ONE     = 64'h0001_0000_0000_0000;
    localparam logic [Q15_W-1:0] Q15_ZERO    = 64'h0000_0000_0000_0000;

    // Result payload leaving a Q15 producer.
    typedef struct packed {
        logic [Q15_W-1:0] q15;
        logic             sat;
    } q15_res_t;

    // Widen a 32-bit operand to 33 bits, sign- or zero-extended.
    function automatic logic [X32_W:0] x32_ext(input logic [X32_W-1:0] data,
                                               input logic             is_signed);
        return {is_signed & data[X32_W-1], data};
    endfunction

endpackage

// File: rtl/q15_saturate.sv
// Combinational saturation of a signed wide value into Q15.
// Ports:
//   wide   in   Q15_WIDE_W  signed value already scaled to 48 fraction bits
//   res_c  out  q15_res_t   {q15, sat}; q15 = +inf / -inf / wide[63:0]
module q15_saturate
    import q15_pkg::*;
(
    input  logic [Q15_WIDE_W-1:0] wide,
    output q15_res_t              res_c
);

    // Bits [80:63] must all agree for the value to fit a signed 64-bit word.
    localparam int unsigned TOP_W = Q15_WIDE_W - Q15_W + 1;

    logic [TOP_W-1:0] top_c;
    logic             fits_c;

    assign top_c  = wide[Q15_WIDE_W-1 -: TOP_W];
    assign fits_c = (top_c == '0) || (top_c == '1);

    // -2^63 fits and passes through as 0x8000..0; only true overflow becomes -inf.
    always_comb begin
        res_c.q15 = wide[Q15_W-1:0];
        res_c.sat = 1'b0;
        if (!fits_c) begin
            res_c.sat = 1'b1;
            res_c.q15 = wide[Q15_WIDE_W-1] ? Q15_NEG_INF : Q15_POS_INF;
        end
    end

endmodule

// File: rtl/x32_to_q15_pipe.sv
// Two-stage i32/u32 fixed-point to Q15 converter with valid/ready on both
// sides. Stage 1 registers the exact widened value, stage 2 registers the
// saturated Q15 result. Full throughput; holds at most two operands.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready input handshake (in_ready combinational from out_ready)
//   in_data           32-bit operand
//   in_signed         1: i32, 0: u32
//   in_frac           fractional bits in in_data (0..31)
//   out_valid/out_ready output handshake
//   out_q15, out_sat  Q15 result and saturation flag
//   sat_count         saturating count of saturated results taken downstream
//   sat_clear         synchronous clear of sat_count (wins over increment)
module x32_to_q15_pipe
    import q15_pkg::*;
#(
    parameter int unsigned SAT_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [X32_W-1:0]      in_data,
    input  logic                  in_signed,
    input  logic [X32_FRAC_W-1:0] in_frac,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Q15_W-1:0]      out_q15,
    output logic                  out_sat,
    output logic [SAT_CNT_W-1:0]  sat_count,
    input  logic                  sat_clear
);

    localparam int unsigned EXT_W = X32_W + 1;

    logic                  s1_valid;
    logic [Q15_WIDE_W-1:0] s1_wide;
    logic                  s2_valid;

    logic                  s1_adv_c;
    logic                  s2_adv_c;
    logic                  accept_c;
    logic [EXT_W-1:0]      ext_c;
    logic [SHAMT_W-1:0]    shamt_c;
    logic [Q15_WIDE_W-1:0] widened_c;
    q15_res_t              sat_res_c;
    logic                  sat_event_c;

    // Pipeline advance conditions.
    assign s2_adv_c  = !s2_valid || out_ready;
    assign s1_adv_c  = !s1_valid || s2_adv_c;
    assign in_ready  = s1_adv_c;
    assign accept_c  = in_valid && s1_adv_c;
    assign out_valid = s2_valid;

    // Scale to 48 fraction bits: shift by 48 - in_frac (17..48), always exact.
    assign ext_c     = x32_ext(in_data, in_signed);
    assign shamt_c   = SHAMT_W'(Q15_FRAC) - SHAMT_W'(in_frac);
    assign widened_c = {{(Q15_WIDE_W-EXT_W){ext_c[EXT_W-1]}}, ext_c} << shamt_c;

    q15_saturate u_sat (
        .wide  (s1_wide),
        .res_c (sat_res_c)
    );

    // Stage 1: widened operand.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_wide  <= '0;
        end else if (s1_adv_c) begin
            s1_valid <= in_valid;
            if (accept_c) begin
                s1_wide <= widened_c;
            end
        end
    end

    // Stage 2: saturated result, held while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_q15  <= Q15_ZERO;
            out_sat  <= 1'b0;
        end else if (s2_adv_c) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_q15 <= sat_res_c.q15;
                out_sat <= sat_res_c.sat;
            end
        end
    end

    // Saturation event counter; sticks at all-ones, clear has priority.
    assign sat_event_c = s2_valid && out_ready && out_sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (sat_clear) begin
            sat_count <= '0;
        end else if (sat_event_c && (sat_count != '1)) begin
            sat_count <= sat_count + SAT_CNT_W'(1);
        end
    end

endmodule
